axi4l_master_engine: RTL and testbench
======================================

Name: axi4l_master_engine

Overview:
- Synthesizable, parametrised AXI4-Lite master. Replaces the task-driven bus model used around the Zynq wrapper.
- Accepts single read/write commands on a valid/ready command port, runs one AXI4-Lite transaction per command on the ca4l_* bus, and returns data/response on a valid/ready response port.
- Improvements over the task model:
  - AW and W are issued concurrently.
  - Data width and protection are parametrised.
  - A per-transaction watchdog timeout is added.
- Sits between PL sequencers (UPS control, PMOD bridge) and any AXI4-Lite slave.

Parameters:
- ADDR_W, 32, address width (ca4l_araddr/awaddr, cmd_addr).
- DATA_W, 32, data width; legal values 32 or 64; STRB_W = DATA_W/8.
- TIMEOUT, 1024, cycles allowed from first valid assertion to final handshake; 0 disables the watchdog.
- PROT, 3'b000, constant driven on ca4l_arprot/awprot.

Ports:
- fclk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  STRB_W  write strobes, passed through unmodified
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  captured RRESP/BRESP; 2'b10 on timeout
- rsp_timeout  out  1  response produced by the watchdog
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst
- ca4l_araddr/arprot/arvalid, ca4l_arready  out/out/out, in  ADDR_W/3/1, 1  AR channel
- ca4l_rdata/rresp/rvalid, ca4l_rready  in/in/in, out  DATA_W/2/1, 1  R channel
- ca4l_awaddr/awprot/awvalid, ca4l_awready  out/out/out, in  ADDR_W/3/1, 1  AW channel
- ca4l_wdata/wstrb/wvalid, ca4l_wready  out/out/out, in  DATA_W/STRB_W/1, 1  W channel
- ca4l_bresp/bvalid, ca4l_bready  in/in, out  2/1, 1  B channel

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - All ca4l_*valid/ready, rsp_valid, rsp_timeout and timeout_err = 0.
  - Address, data, rdata and resp registers = 0.
  - State = IDLE.
  - Reset mid-transaction drops all valids immediately; no response is produced.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- cmd_ready = (state == IDLE), registered-output equivalent; only one transaction is ever outstanding.
- IDLE, on cmd handshake at edge N:
  - Latch addr, wdata and wstrb.
  - Read: arvalid = 1 from cycle N+1; go to RD_ADDR.
  - Write: awvalid = 1 and wvalid = 1 from cycle N+1; go to WR_REQ.
- RD_ADDR:
  - Hold araddr/arvalid stable until arvalid & arready.
  - Then arvalid = 0, rready = 1; go to RD_DATA.
- RD_DATA:
  - On rvalid & rready: capture rdata and rresp; rready = 0; go to RSP.
- WR_REQ:
  - awvalid and wvalid drop independently on their own handshakes; either order and same-cycle are all legal.
  - When both are done (tracked by aw_done/w_done flags), bready = 1; go to WR_RESP.
  - If both handshake on the same edge, bready rises the next cycle.
- WR_RESP:
  - On bvalid & bready: capture bresp; bready = 0; go to RSP.
- RSP:
  - rsp_valid = 1, held with stable data until rsp_ready.
  - Then go to IDLE; cmd_ready rises the next cycle.
  - Minimum cmd-to-cmd period with zero-wait slave and rsp_ready tied high: read 4 cycles, write 4 cycles.
- Watchdog:
  - 16-bit counter cleared on cmd accept; increments in every non-IDLE, non-RSP state.
  - When the count reaches TIMEOUT:
    - Drop all ca4l valids/readies.
    - rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
    - Set timeout_err; go to RSP.
  - A late slave response after a timeout is not tracked; the system must reset the slave.
  - A handshake on the same edge as the expiry wins, and no timeout is declared.
  - The watchdog does not run in RSP, so rsp_ready backpressure never times out.
- Unaligned addresses are passed through unmodified; no alignment checks.

Decomposition:
- Package axi4l_pkg:
  - Response constants RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - Enum type for the state.
  - Function strb_w(DATA_W).
- Sub-module axi4l_watchdog: counter, enable, clear and expire pulse, parametrised by TIMEOUT.
- Everything else lives in a single FSM module.

Test Plan:
- Write addr 0x0, data 0x10, strb 0xF; slave awready delayed 2 cycles, wready immediate -> wvalid drops first, then awvalid; single B handshake; rsp_resp = 0, rsp_timeout = 0.
- Read addr 0x0 from a memory slave after that write -> rsp_rdata = 0x00000010, rsp_resp = 0; arvalid held stable until arready.
- Write 0x2 <- 0xC38D with awready and wready high in the same cycle -> bready asserted exactly 1 cycle later; back-to-back read of 0x2 returns 0x0000C38D.
- Slave returns RRESP = 2'b10 on read of 0x1 -> rsp_resp = 2'b10, rsp_timeout = 0, timeout_err stays 0.
- TIMEOUT = 16, slave never asserts arready -> arvalid drops after 16 cycles; rsp_resp = 2'b10, rsp_timeout = 1, timeout_err = 1 (sticky), next command accepted normally.
- rsp_ready held low 10 cycles -> rsp_valid and data stable, cmd_ready = 0 throughout.
- rst asserted during WR_REQ -> all valids 0 immediately, no rsp_valid.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared definitions for the AXI4-Lite master engine: response codes,
// FSM state encoding and the strobe-width helper.
package axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RSP
  } state_e;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi4l_watchdog.sv
// Per-transaction watchdog: counts cycles while a bus transaction is in
// flight and flags expiry once TIMEOUT cycles have elapsed. TIMEOUT = 0
// disables expiry entirely.
module axi4l_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam bit          WD_ON = (TIMEOUT != 0);
  localparam int unsigned LIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [15:0] LIM_W = 16'(LIM);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear on command accept, count while armed, saturate at max
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is seen during the cycle whose closing edge would make the count
  // reach TIMEOUT; it stays asserted afterwards so later phases cannot
  // extend the overall budget.
  assign expire_o = WD_ON && en_i && (cnt_q >= LIM_W);

endmodule

// File: rtl/axi4l_master_engine.sv
// AXI4-Lite master: accepts one read/write command at a time, runs a single
// bus transaction (AW and W issued together for writes) and returns the
// captured data/response. A watchdog aborts transactions that stall.
module axi4l_master_engine
  import axi4l_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          TIMEOUT = 1024,
  parameter logic [2:0]  PROT    = 3'b000,
  localparam int         STRB_W  = strb_w(DATA_W)
) (
  input  logic              fclk,
  input  logic              rst,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              timeout_err,
  // AR channel
  output logic [ADDR_W-1:0] ca4l_araddr,
  output logic [2:0]        ca4l_arprot,
  output logic              ca4l_arvalid,
  input  logic              ca4l_arready,
  // R channel
  input  logic [DATA_W-1:0] ca4l_rdata,
  input  logic [1:0]        ca4l_rresp,
  input  logic              ca4l_rvalid,
  output logic              ca4l_rready,
  // AW channel
  output logic [ADDR_W-1:0] ca4l_awaddr,
  output logic [2:0]        ca4l_awprot,
  output logic              ca4l_awvalid,
  input  logic              ca4l_awready,
  // W channel
  output logic [DATA_W-1:0] ca4l_wdata,
  output logic [STRB_W-1:0] ca4l_wstrb,
  output logic              ca4l_wvalid,
  input  logic              ca4l_wready,
  // B channel
  input  logic [1:0]        ca4l_bresp,
  input  logic              ca4l_bvalid,
  output logic              ca4l_bready
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;
  logic                rsp_timeout_q;
  logic                timeout_err_q;

  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic phase_done;
  logic wd_en;
  logic wd_expire;
  logic to_fire;

  assign cmd_ready = (state_q == ST_IDLE);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign wd_en     = (state_q != ST_IDLE) && (state_q != ST_RSP);

  axi4l_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk_i    (fclk),
    .rst_i    (rst),
    .clr_i    (cmd_hs),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Handshake decode and "phase completes this edge" so a handshake coinciding
  // with watchdog expiry takes priority over the timeout
  always_comb begin
    aw_hs      = awvalid_q && ca4l_awready;
    w_hs       = wvalid_q && ca4l_wready;
    aw_fin     = aw_done_q || aw_hs;
    w_fin      = w_done_q || w_hs;
    phase_done = 1'b0;
    case (state_q)
      ST_RD_ADDR: phase_done = ca4l_arready;
      ST_RD_DATA: phase_done = ca4l_rvalid;
      ST_WR_REQ:  phase_done = aw_fin && w_fin;
      ST_WR_RESP: phase_done = ca4l_bvalid;
      default:    phase_done = 1'b0;
    endcase
    to_fire = wd_expire && !phase_done;
  end

  // Transaction FSM with registered bus and response outputs
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (cmd_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (ca4l_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (ca4l_rvalid) begin
            rready_q      <= 1'b0;
            rsp_rdata_q   <= ca4l_rdata;
            rsp_resp_q    <= ca4l_rresp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RSP;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (ca4l_bvalid) begin
            bready_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= ca4l_bresp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Watchdog abort overrides whatever the active phase scheduled
      if (to_fire) begin
        arvalid_q     <= 1'b0;
        rready_q      <= 1'b0;
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        bready_q      <= 1'b0;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= RESP_SLVERR;
        rsp_timeout_q <= 1'b1;
        rsp_valid_q   <= 1'b1;
        timeout_err_q <= 1'b1;
        state_q       <= ST_RSP;
      end
    end
  end

  assign ca4l_araddr  = addr_q;
  assign ca4l_arprot  = PROT;
  assign ca4l_arvalid = arvalid_q;
  assign ca4l_rready  = rready_q;
  assign ca4l_awaddr  = addr_q;
  assign ca4l_awprot  = PROT;
  assign ca4l_awvalid = awvalid_q;
  assign ca4l_wdata   = wdata_q;
  assign ca4l_wstrb   = wstrb_q;
  assign ca4l_wvalid  = wvalid_q;
  assign ca4l_bready  = bready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_axi4l_master_engine.sv
// Directed bench for axi4l_master_engine with a memory-backed AXI4-Lite
// slave model and a response scoreboard.
module tb_axi4l_master_engine;

  localparam int         AW   = 32;
  localparam int         DW   = 32;
  localparam int         SW   = 4;
  localparam int         TO   = 16;
  localparam logic [2:0] PROT = 3'b010;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  logic          fclk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic          timeout_err;
  logic [AW-1:0] ca4l_araddr;
  logic [2:0]    ca4l_arprot;
  logic          ca4l_arvalid;
  logic          ca4l_arready;
  logic [DW-1:0] ca4l_rdata;
  logic [1:0]    ca4l_rresp;
  logic          ca4l_rvalid;
  logic          ca4l_rready;
  logic [AW-1:0] ca4l_awaddr;
  logic [2:0]    ca4l_awprot;
  logic          ca4l_awvalid;
  logic          ca4l_awready;
  logic [DW-1:0] ca4l_wdata;
  logic [SW-1:0] ca4l_wstrb;
  logic          ca4l_wvalid;
  logic          ca4l_wready;
  logic [1:0]    ca4l_bresp;
  logic          ca4l_bvalid;
  logic          ca4l_bready;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // slave model knobs and state
  logic [31:0] mem [0:15];
  int          aw_delay, w_delay, ar_delay;
  int          aw_cnt, w_cnt, ar_cnt, b_count;
  bit          ar_never;
  logic [31:0] err_addr;
  bit          aw_have, w_have, ar_have, b_fire, r_fire;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;

  axi4l_master_engine #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .PROT    (PROT)
  ) dut (
    .fclk         (fclk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .timeout_err  (timeout_err),
    .ca4l_araddr  (ca4l_araddr),
    .ca4l_arprot  (ca4l_arprot),
    .ca4l_arvalid (ca4l_arvalid),
    .ca4l_arready (ca4l_arready),
    .ca4l_rdata   (ca4l_rdata),
    .ca4l_rresp   (ca4l_rresp),
    .ca4l_rvalid  (ca4l_rvalid),
    .ca4l_rready  (ca4l_rready),
    .ca4l_awaddr  (ca4l_awaddr),
    .ca4l_awprot  (ca4l_awprot),
    .ca4l_awvalid (ca4l_awvalid),
    .ca4l_awready (ca4l_awready),
    .ca4l_wdata   (ca4l_wdata),
    .ca4l_wstrb   (ca4l_wstrb),
    .ca4l_wvalid  (ca4l_wvalid),
    .ca4l_wready  (ca4l_wready),
    .ca4l_bresp   (ca4l_bresp),
    .ca4l_bvalid  (ca4l_bvalid),
    .ca4l_bready  (ca4l_bready)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=no_finish expected=finish");
    $fatal(1, "simulation time limit");
  end

  function automatic exp_t mk(input logic [31:0] rd, input logic [1:0] rs, input logic t);
    exp_t e;
    e.rdata = rd;
    e.resp  = rs;
    e.to    = t;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Slave model: decisions are made on the falling edge and take effect at
  // the next rising edge, so a ready raised here against a held valid means a
  // handshake at that next edge.
  initial begin
    ca4l_awready = 0; ca4l_wready = 0; ca4l_arready = 0;
    ca4l_rvalid = 0; ca4l_rdata = 0; ca4l_rresp = 0;
    ca4l_bvalid = 0; ca4l_bresp = 0;
    aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_count = 0;
    aw_a = 0; w_d = 0; w_s = 0; ar_a = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    forever begin
      @(negedge fclk);
      if (rst) begin
        ca4l_awready = 0; ca4l_wready = 0; ca4l_arready = 0;
        ca4l_rvalid = 0; ca4l_bvalid = 0;
        aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        continue;
      end
      if (b_fire) begin ca4l_bvalid = 0; b_fire = 0; b_count++; end
      if (r_fire) begin ca4l_rvalid = 0; r_fire = 0; end
      if (aw_have && w_have && !ca4l_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem[aw_a[3:0]][8*b +: 8] = w_d[8*b +: 8];
        ca4l_bvalid = 1; ca4l_bresp = 2'b00;
        aw_have = 0; w_have = 0;
      end
      if (ar_have && !ca4l_rvalid) begin
        ca4l_rvalid = 1;
        ca4l_rdata  = mem[ar_a[3:0]];
        ca4l_rresp  = (ar_a == err_addr) ? 2'b10 : 2'b00;
        ar_have = 0;
      end
      if (ca4l_bvalid && ca4l_bready) b_fire = 1;
      if (ca4l_rvalid && ca4l_rready) r_fire = 1;
      ca4l_awready = 0;
      if (ca4l_awvalid) begin
        if (aw_cnt >= aw_delay) begin
          ca4l_awready = 1; aw_have = 1; aw_a = ca4l_awaddr; aw_cnt = 0;
        end else aw_cnt++;
      end else aw_cnt = 0;
      ca4l_wready = 0;
      if (ca4l_wvalid) begin
        if (w_cnt >= w_delay) begin
          ca4l_wready = 1; w_have = 1; w_d = ca4l_wdata; w_s = ca4l_wstrb; w_cnt = 0;
        end else w_cnt++;
      end else w_cnt = 0;
      ca4l_arready = 0;
      if (ca4l_arvalid && !ar_never) begin
        if (ar_cnt >= ar_delay) begin
          ca4l_arready = 1; ar_have = 1; ar_a = ca4l_araddr; ar_cnt = 0;
        end else ar_cnt++;
      end else ar_cnt = 0;
    end
  end

  // Drive one command; returns on the falling edge of the first cycle after
  // acceptance.
  task automatic send_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input exp_t e, input bit push);
    int n;
    n = 0;
    @(negedge fclk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(negedge fclk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    if (push) exp_q.push_back(e);
    @(negedge fclk);
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, optionally hold it with rsp_ready low, then compare
  // against the scoreboard head and consume it.
  task automatic get_rsp(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge fclk); n++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold"}, {rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout},
          {1'b1, 1'b0, e.rdata, e.resp, e.to});
      @(negedge fclk);
    end
    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_resp"}, rsp_resp, e.resp);
    chk({tag, "_timeout"}, rsp_timeout, e.to);
    rsp_ready = 1'b1;
    @(negedge fclk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    int b0;
    int n;
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    aw_delay = 0; w_delay = 0; ar_delay = 0; ar_never = 0; err_addr = 32'hFFFF_FFFF;
    repeat (3) @(negedge fclk);
    chk("reset_ctl", {ca4l_arvalid, ca4l_rready, ca4l_awvalid, ca4l_wvalid, ca4l_bready,
                      rsp_valid, rsp_timeout, timeout_err}, 8'h00);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_addr_data", {ca4l_araddr, ca4l_wdata}, 64'h0);
    chk("reset_rsp", {rsp_rdata, rsp_resp}, 34'h0);
    rst = 1'b0;
    @(negedge fclk);

    // write 0x0 <- 0x10, awready delayed 2 cycles, wready immediate
    aw_delay = 2; w_delay = 0; b0 = b_count;
    send_cmd(1'b1, 32'h0, 32'h10, 4'hF, mk(32'h0, 2'b00, 1'b0), 1'b1);
    chk("t1_c1", {ca4l_awvalid, ca4l_wvalid, ca4l_bready}, 3'b110);
    chk("t1_awaddr_wdata", {ca4l_awaddr, ca4l_wdata}, {32'h0, 32'h10});
    chk("t1_wstrb", ca4l_wstrb, 4'hF);
    chk("t1_prot", {ca4l_awprot, ca4l_arprot}, {PROT, PROT});
    @(negedge fclk);
    chk("t1_c2", {ca4l_awvalid, ca4l_wvalid, ca4l_bready}, 3'b100);
    @(negedge fclk);
    chk("t1_c3", {ca4l_awvalid, ca4l_wvalid, ca4l_bready}, 3'b100);
    @(negedge fclk);
    chk("t1_c4", {ca4l_awvalid, ca4l_wvalid, ca4l_bready}, 3'b001);
    get_rsp("t1", 0);
    chk("t1_b_count", b_count - b0, 1);

    // read 0x0, arready delayed 2 cycles
    aw_delay = 0; ar_delay = 2;
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, mk(32'h0000_0010, 2'b00, 1'b0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_ar_hold", {ca4l_arvalid, ca4l_araddr}, {1'b1, 32'h0});
      @(negedge fclk);
    end
    chk("t2_r_phase", {ca4l_arvalid, ca4l_rready}, 2'b01);
    get_rsp("t2", 0);

    // write 0x2 <- 0xC38D with AW and W accepted on the same edge
    ar_delay = 0;
    send_cmd(1'b1, 32'h2, 32'h0000_C38D, 4'hF, mk(32'h0, 2'b00, 1'b0), 1'b1);
    chk("t3_c1", {ca4l_awvalid, ca4l_wvalid, ca4l_bready}, 3'b110);
    @(negedge fclk);
    chk("t3_c2", {ca4l_awvalid, ca4l_wvalid, ca4l_bready}, 3'b001);
    get_rsp("t3w", 0);
    send_cmd(1'b0, 32'h2, 32'h0, 4'h0, mk(32'h0000_C38D, 2'b00, 1'b0), 1'b1);
    get_rsp("t3r", 0);

    // slave error response on read of 0x1
    err_addr = 32'h1;
    send_cmd(1'b0, 32'h1, 32'h0, 4'h0, mk(32'h0, 2'b10, 1'b0), 1'b1);
    get_rsp("t4", 0);
    chk("t4_timeout_err", timeout_err, 0);
    err_addr = 32'hFFFF_FFFF;

    // slave never accepts AR -> watchdog
    ar_never = 1;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0, mk(32'h0, 2'b10, 1'b1), 1'b1);
    n = 0;
    while (ca4l_arvalid && n < 40) begin n++; @(negedge fclk); end
    chk("t5_ar_cycles", n, TO);
    chk("t5_after", {ca4l_arvalid, ca4l_rready, rsp_valid}, 3'b001);
    get_rsp("t5", 0);
    chk("t5_timeout_err", timeout_err, 1);
    ar_never = 0;

    // next command proceeds normally; response held off 10 cycles
    send_cmd(1'b0, 32'h2, 32'h0, 4'h0, mk(32'h0000_C38D, 2'b00, 1'b0), 1'b1);
    get_rsp("t6", 10);
    chk("t6_timeout_err_sticky", timeout_err, 1);

    // reset in the middle of a write request
    aw_delay = 5; w_delay = 5;
    send_cmd(1'b1, 32'h3, 32'h55, 4'hF, mk(32'h0, 2'b00, 1'b0), 1'b0);
    chk("t7_wr_req", {ca4l_awvalid, ca4l_wvalid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_drop", {ca4l_arvalid, ca4l_rready, ca4l_awvalid, ca4l_wvalid, ca4l_bready,
                        rsp_valid, rsp_timeout, timeout_err}, 8'h00);
    repeat (2) @(negedge fclk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge fclk);
      if (rsp_valid) n++;
    end
    chk("t7_no_rsp", n, 0);
    chk("t7_cmd_ready", cmd_ready, 1);
    chk("t7_mem_untouched", mem[3], 32'h0);

    // recovery read
    aw_delay = 0; w_delay = 0;
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, mk(32'h0000_0010, 2'b00, 1'b0), 1'b1);
    get_rsp("t8", 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
